// File: rtl/if_id_expand.sv
// Fetch-to-decode stage: RV32C expansion, illegal-encoding detection,
// one-entry skid buffer so a decode stall never drops a fetched word.
module if_id_expand #(
  parameter int unsigned XLEN = 32,
  parameter logic [31:0] NOP  = 32'h00000013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     ins_in,
  input  logic            comp_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            stall,
  input  logic            flush,
  output logic [31:0]     ins_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_next_out,
  output logic            comp_out,
  output logic            illegal_out,
  output logic            valid_out
);

  // returns {illegal, expanded instruction}
  function automatic logic [32:0] expand(input logic [15:0] c);
    logic [31:0] r;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs2;
    logic [4:0]  rdp;
    logic [4:0]  rs2p;
    logic [20:1] joff;
    logic [12:1] boff;
    logic [11:0] imm6;
    logic [2:0]  f3;
    logic [6:0]  f7;
    r    = NOP;
    ill  = 1'b0;
    f3   = 3'b000;
    f7   = 7'h00;
    rd   = c[11:7];
    rs2  = c[6:2];
    rdp  = {2'b01, c[9:7]};
    rs2p = {2'b01, c[4:2]};
    joff = {{10{c[12]}}, c[8], c[10:9], c[6], c[7],
            c[2], c[11], c[5:3]};
    boff = {{5{c[12]}}, c[6:5], c[2], c[11:10], c[4:3]};
    imm6 = {{7{c[12]}}, c[6:2]};
    case ({c[1:0], c[15:13]})
      5'b00_000: begin
        r   = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00,
               5'd2, 3'b000, rs2p, 7'h13};
        ill = (c[12:5] == 8'd0);
      end
      5'b00_010:
        r = {5'b0, c[5], c[12:10], c[6], 2'b00,
             rdp, 3'b010, rs2p, 7'h03};
      5'b00_110:
        r = {5'b0, c[5], c[12], rs2p, rdp, 3'b010,
             c[11:10], c[6], 2'b00, 7'h23};
      5'b01_000:
        r = {imm6, rd, 3'b000, rd, 7'h13};
      5'b01_001:
        r = {joff[20], joff[10:1], joff[11], joff[19:12],
             5'd1, 7'h6f};
      5'b01_010:
        r = {imm6, 5'd0, 3'b000, rd, 7'h13};
      5'b01_011: begin
        ill = ~c[12] & (c[6:2] == 5'd0);
        if (rd == 5'd2)
          r = {{2{c[12]}}, c[12], c[4:3], c[5], c[2], c[6],
               4'b0000, 5'd2, 3'b000, 5'd2, 7'h13};
        else
          r = {{14{c[12]}}, c[12], c[6:2], rd, 7'h37};
      end
      5'b01_100: begin
        case (c[11:10])
          2'b00: begin
            r   = {7'h00, c[6:2], rdp, 3'b101, rdp, 7'h13};
            ill = c[12];
          end
          2'b01: begin
            r   = {7'h20, c[6:2], rdp, 3'b101, rdp, 7'h13};
            ill = c[12];
          end
          2'b10:
            r = {imm6, rdp, 3'b111, rdp, 7'h13};
          default: begin
            case (c[6:5])
              2'b00: begin f3 = 3'b000; f7 = 7'h20; end
              2'b01: f3 = 3'b100;
              2'b10: f3 = 3'b110;
              default: f3 = 3'b111;
            endcase
            r   = {f7, rs2p, rdp, f3, rdp, 7'h33};
            ill = c[12];
          end
        endcase
      end
      5'b01_101:
        r = {joff[20], joff[10:1], joff[11], joff[19:12],
             5'd0, 7'h6f};
      5'b01_110:
        r = {boff[12], boff[10:5], 5'd0, rdp, 3'b000,
             boff[4:1], boff[11], 7'h63};
      5'b01_111:
        r = {boff[12], boff[10:5], 5'd0, rdp, 3'b001,
             boff[4:1], boff[11], 7'h63};
      5'b10_000: begin
        r   = {7'h00, c[6:2], rd, 3'b001, rd, 7'h13};
        ill = c[12];
      end
      5'b10_010: begin
        r   = {4'b0, c[3:2], c[12], c[6:4], 2'b00,
               5'd2, 3'b010, rd, 7'h03};
        ill = (rd == 5'd0);
      end
      5'b10_100: begin
        if (!c[12]) begin
          if (rs2 == 5'd0) begin
            r   = {12'd0, rd, 3'b000, 5'd0, 7'h67};
            ill = (rd == 5'd0);
          end else begin
            r = {7'h00, rs2, 5'd0, 3'b000, rd, 7'h33};
          end
        end else if (rs2 == 5'd0) begin
          if (rd == 5'd0)
            r = 32'h00100073;
          else
            r = {12'd0, rd, 3'b000, 5'd1, 7'h67};
        end else begin
          r = {7'h00, rs2, rd, 3'b000, rd, 7'h33};
        end
      end
      5'b10_110:
        r = {4'b0, c[8:7], c[12], rs2, 5'd2, 3'b010,
             c[11:9], 2'b00, 7'h23};
      default:
        ill = 1'b1;
    endcase
    if (ill) r = NOP;
    return {ill, r};
  endfunction

  logic            skid_full;
  logic [31:0]     skid_ins;
  logic [XLEN-1:0] skid_pc;
  logic            skid_comp;

  logic            accept;
  logic [31:0]     src_ins;
  logic [XLEN-1:0] src_pc;
  logic            src_comp;
  logic [32:0]     exp_c;
  logic [31:0]     src_out;
  logic            src_ill;

  assign in_ready = ~skid_full;
  assign accept   = in_valid & in_ready;

  // skid contents are older than the input, so they drain first
  assign src_ins  = skid_full ? skid_ins  : ins_in;
  assign src_pc   = skid_full ? skid_pc   : pc_in;
  assign src_comp = skid_full ? skid_comp : comp_in;
  assign exp_c    = expand(src_ins[15:0]);

  always_comb begin
    src_out = src_ins;
    src_ill = (src_ins[1:0] != 2'b11) | (src_ins == 32'd0);
    if (src_comp) begin
      src_out = exp_c[31:0];
      src_ill = exp_c[32];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ins_out     <= NOP;
      pc_out      <= '0;
      pc_next_out <= '0;
      comp_out    <= 1'b0;
      illegal_out <= 1'b0;
      valid_out   <= 1'b0;
      skid_full   <= 1'b0;
      skid_ins    <= '0;
      skid_pc     <= '0;
      skid_comp   <= 1'b0;
    end else if (flush) begin
      valid_out   <= 1'b0;
      ins_out     <= NOP;
      illegal_out <= 1'b0;
      comp_out    <= 1'b0;
      skid_full   <= 1'b0;
    end else if (stall) begin
      if (accept) begin
        skid_ins  <= ins_in;
        skid_pc   <= pc_in;
        skid_comp <= comp_in;
        skid_full <= 1'b1;
      end
    end else if (skid_full || accept) begin
      ins_out     <= src_out;
      pc_out      <= src_pc;
      pc_next_out <= src_pc + (src_comp ? XLEN'(2) : XLEN'(4));
      comp_out    <= src_comp;
      illegal_out <= src_ill;
      valid_out   <= 1'b1;
      if (skid_full) begin
        skid_full <= accept;
        if (accept) begin
          skid_ins  <= ins_in;
          skid_pc   <= pc_in;
          skid_comp <= comp_in;
        end
      end
    end else begin
      valid_out <= 1'b0;
      ins_out   <= NOP;
    end
  end

endmodule

// File: tb/tb_if_id_expand.sv
// Bench for if_id_expand: expansion vector table through a scoreboard,
// plus hand sequences for stall/skid, flush and async reset.
module tb_if_id_expand;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins_in = '0;
  logic        comp_in = 1'b0;
  logic [31:0] pc_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ins_out;
  logic [31:0] pc_out;
  logic [31:0] pc_next_out;
  logic        comp_out;
  logic        illegal_out;
  logic        valid_out;

  if_id_expand dut (
    .clk(clk), .rst(rst),
    .ins_in(ins_in), .comp_in(comp_in), .pc_in(pc_in),
    .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush),
    .ins_out(ins_out), .pc_out(pc_out),
    .pc_next_out(pc_next_out), .comp_out(comp_out),
    .illegal_out(illegal_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ins;
    logic        comp;
    logic [31:0] pc;
    logic [31:0] exp_ins;
    logic        exp_ill;
  } vec_t;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        comp;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  logic stall_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic comp,
                              input logic [31:0] pc, input logic [31:0] e,
                              input logic ill);
    vec_t v;
    v.ins = ins; v.comp = comp; v.pc = pc;
    v.exp_ins = e; v.exp_ill = ill;
    return v;
  endfunction

  function automatic exp_t model(input vec_t v);
    exp_t e;
    e.ins     = v.exp_ins;
    e.pc      = v.pc;
    e.pc_next = v.pc + (v.comp ? 32'd2 : 32'd4);
    e.comp    = v.comp;
    e.ill     = v.exp_ill;
    return e;
  endfunction

  task automatic offer(input vec_t v, input bit track);
    ins_in   = v.ins;
    comp_in  = v.comp;
    pc_in    = v.pc;
    in_valid = 1'b1;
    if (track && in_ready) sb.push_back(model(v));
  endtask

  always @(posedge clk) stall_seen <= stall;

  // scoreboard: every freshly loaded valid output must match the queue head
  always @(negedge clk) begin
    exp_t e;
    if (!rst && !stall_seen && valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h expected none", ins_out);
      end else begin
        e = sb.pop_front();
        chk("ins_out", ins_out, e.ins);
        chk("illegal_out", 32'(illegal_out), 32'(e.ill));
        chk("comp_out", 32'(comp_out), 32'(e.comp));
        chk("pc_out", pc_out, e.pc);
        chk("pc_next_out", pc_next_out, e.pc_next);
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_ins"}, ins_out, NOP);
    chk({tag, "_pc"}, pc_out, 32'd0);
    chk({tag, "_pcnext"}, pc_next_out, 32'd0);
    chk({tag, "_comp"}, 32'(comp_out), 32'd0);
    chk({tag, "_ill"}, 32'(illegal_out), 32'd0);
    chk({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs.push_back(mk(32'h00004515, 1, 32'h100, 32'h00500513, 0));
    vecs.push_back(mk(32'h0000852E, 1, 32'h102, 32'h00B00533, 0));
    vecs.push_back(mk(32'h00008082, 1, 32'h104, 32'h00008067, 0));
    vecs.push_back(mk(32'h00000001, 1, 32'h106, 32'h00000013, 0));
    vecs.push_back(mk(32'h00150513, 0, 32'h104, 32'h00150513, 0));
    vecs.push_back(mk(32'h00000000, 1, 32'h108, 32'h00000013, 1));
    vecs.push_back(mk(32'h00000000, 0, 32'h10A, 32'h00000000, 1));
    vecs.push_back(mk(32'h00000512, 0, 32'h10E, 32'h00000512, 1));
    vecs.push_back(mk(32'h00000040, 1, 32'h112, 32'h00410413, 0));
    vecs.push_back(mk(32'h00004044, 1, 32'h114, 32'h00442483, 0));
    vecs.push_back(mk(32'h00006081, 1, 32'h116, 32'h00000013, 1));
    vecs.push_back(mk(32'h0000717D, 1, 32'h118, 32'hFF010113, 0));
    vecs.push_back(mk(32'h00009005, 1, 32'h11A, 32'h00000013, 1));
    vecs.push_back(mk(32'h00008C05, 1, 32'h11C, 32'h40940433, 0));
    vecs.push_back(mk(32'h0000C401, 1, 32'h11E, 32'h00040463, 0));
    vecs.push_back(mk(32'h00003FFD, 1, 32'h120, 32'hFFFFF0EF, 0));
    vecs.push_back(mk(32'h00004002, 1, 32'h122, 32'h00000013, 1));
    vecs.push_back(mk(32'h0000C206, 1, 32'h124, 32'h00112223, 0));
    vecs.push_back(mk(32'h00009002, 1, 32'h126, 32'h00100073, 0));
    vecs.push_back(mk(32'h00006000, 1, 32'h128, 32'h00000013, 1));
    vecs.push_back(mk(32'h00000001, 1, 32'hFFFFFFFE, 32'h00000013, 0));

    #12;
    chk_reset_vals("reset");
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    // back-to-back stream, one per cycle
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      chk("in_ready_stream", 32'(in_ready), 32'd1);
      offer(vecs[i], 1'b1);
    end
    @(negedge clk) in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("bubble_valid", 32'(valid_out), 32'd0);
    chk("bubble_ins", ins_out, NOP);

    // stall 3 cycles while fetch presents A then B
    @(negedge clk);
    stall = 1'b1;
    offer(mk(32'h0000852E, 1, 32'h200, 32'h00B00533, 0), 1'b1);
    @(negedge clk);
    chk("stall_ready", 32'(in_ready), 32'd0);
    chk("stall_hold_valid", 32'(valid_out), 32'd0);
    offer(mk(32'h00150513, 0, 32'h202, 32'h00150513, 0), 1'b0);
    @(negedge clk);
    chk("stall_ready2", 32'(in_ready), 32'd0);
    chk("stall_hold_ins", ins_out, NOP);
    @(negedge clk);
    stall = 1'b0;
    chk("stall_ready3", 32'(in_ready), 32'd0);
    @(negedge clk);
    chk("drain_valid_a", 32'(valid_out), 32'd1);
    chk("drain_ready", 32'(in_ready), 32'd1);
    offer(mk(32'h00150513, 0, 32'h202, 32'h00150513, 0), 1'b1);
    @(negedge clk);
    chk("drain_valid_b", 32'(valid_out), 32'd1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // flush with skid full and a valid input waiting
    offer(mk(32'h00004515, 1, 32'h300, 32'h00500513, 0), 1'b1);
    @(negedge clk);
    stall = 1'b1;
    offer(mk(32'h00000001, 1, 32'h302, 32'h00000013, 0), 1'b0);
    @(negedge clk);
    chk("pre_flush_ready", 32'(in_ready), 32'd0);
    chk("pre_flush_hold", 32'(valid_out), 32'd1);
    flush = 1'b1;
    offer(mk(32'h00008082, 1, 32'h310, 32'h00008067, 0), 1'b0);
    @(negedge clk);
    flush = 1'b0;
    stall = 1'b0;
    chk("flush_valid", 32'(valid_out), 32'd0);
    chk("flush_ins", ins_out, NOP);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_comp", 32'(comp_out), 32'd0);
    offer(mk(32'h00008082, 1, 32'h310, 32'h00008067, 0), 1'b1);
    @(negedge clk);
    chk("post_flush_valid", 32'(valid_out), 32'd1);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    // async reset pulse mid-stall with skid full
    offer(mk(32'h00000001, 1, 32'h400, 32'h00000013, 0), 1'b1);
    @(negedge clk);
    stall = 1'b1;
    offer(mk(32'h00008082, 1, 32'h402, 32'h00008067, 0), 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_ready", 32'(in_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    @(negedge clk);
    rst = 1'b0;
    stall = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_stale_valid", 32'(valid_out), 32'd0);
    end
    offer(mk(32'h00150513, 0, 32'h500, 32'h00150513, 0), 1'b1);
    @(negedge clk) in_valid = 1'b0;

    // bounded drain of the scoreboard
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_expand.md
Name: if_id_expand

Overview:
- Fetch-to-decode pipeline stage sitting directly downstream of the compressed-aware fetch unit.
- Accepts the fetch unit's 32-bit instruction word, PC and compressed flag.
- Expands RV32C 16-bit encodings to their 32-bit RV32I equivalents, flags illegal encodings, and registers the result for decode.
- Contains a one-entry skid buffer so a decode stall never drops a fetched instruction.

Parameters:
- XLEN, 32, datapath/PC width
- NOP, 32'h00000013, instruction emitted on bubble/flush/reset (addi x0,x0,0)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-high reset
- ins_in  input  32  instruction from fetch; compressed encodings occupy [15:0], with [31:16] zero
- comp_in  input  1  fetch's compressed flag for ins_in
- pc_in  input  XLEN  address of ins_in
- in_valid  input  1  ins_in/pc_in/comp_in valid this cycle
- in_ready  output  1  stage can accept an input this cycle
- stall  input  1  decode cannot accept; hold outputs
- flush  input  1  branch/jump redirect; discard all held and incoming instructions
- ins_out  output  32  expanded 32-bit instruction to decode
- pc_out  output  XLEN  PC of ins_out
- pc_next_out  output  XLEN  pc_out+2 if compressed, else pc_out+4 (for link address)
- comp_out  output  1  ins_out originated from a 16-bit encoding
- illegal_out  output  1  source encoding illegal or reserved
- valid_out  output  1  ins_out holds a real instruction

Behaviour:
- Reset (async, immediate):
  - ins_out=NOP; pc_out=0; pc_next_out=0; comp_out=0; illegal_out=0; valid_out=0.
  - Skid buffer empty; in_ready=1 as soon as rst deasserts.
- Latency: one cycle from an accepted input to the output register when not stalled.
- Accept:
  - in_ready = ~skid_full (registered-state only; no combinational path from stall).
  - An input is accepted when in_valid & in_ready.
- Expansion (combinational on the selected source word, before the output register):
  - comp_in=1: decode ins_in[15:0] per the RV32C expansion table (quadrants 0/1/2, RV32 only). Covers c.addi4spn, c.lw, c.sw, c.nop, c.addi, c.jal, c.li, c.addi16sp, c.lui, c.srli, c.srai, c.andi, c.sub, c.xor, c.or, c.and, c.j, c.beqz, c.bnez, c.slli, c.lwsp, c.jr, c.mv, c.ebreak, c.jalr, c.add, c.swsp.
  - Compressed-register fields (rd'/rs1'/rs2') map to x8-x15.
  - Immediates are sign- or zero-extended per the ISA.
  - Illegal (illegal_out=1, ins_out=NOP): all-zero halfword; c.addi4spn with nzuimm=0; c.lwsp with rd=0; c.jr with rs1=0; c.lui/c.addi16sp with imm=0; c.lui rd=2 handled as c.addi16sp; RV64/FP-only encodings (c.fld, c.flw, c.fsd, c.fsw, c.ldsp, c.sdsp, c.subw, c.addw); shift with shamt[5]=1.
  - Hint encodings (rd=0 forms, c.addi with imm=0) expand normally and are not illegal.
  - comp_in=0: ins_out=ins_in. illegal_out=1 if ins_in[1:0]!=2'b11 or ins_in==0.
- Output register update per cycle, in priority order:
  1. flush: valid_out<=0, ins_out<=NOP, illegal_out<=0, comp_out<=0. Skid buffer cleared. Any input accepted this cycle is discarded.
  2. stall: outputs hold. An accepted input is written to the skid buffer (skid_full<=1).
  3. otherwise, skid_full: load outputs from the skid buffer's expanded word and clear skid_full. Any input accepted the same cycle loads into the skid buffer, so skid_full stays 1. Order is preserved.
  4. otherwise, accepted input: load outputs from the input, valid_out<=1.
  5. otherwise: valid_out<=0, ins_out<=NOP.
- pc_next_out is computed from the registered PC and comp bit. Arithmetic wraps modulo 2^XLEN (PC 0xFFFFFFFE, compressed -> pc_next 0x00000000).
- Skid buffer stores the raw ins_in, pc_in and comp_in; expansion is done when it drains.
- Assertion of rst mid-stall discards both the output register and the skid contents.

Test Plan:
- comp_in=1, ins_in=0x00004515, pc_in=0x100 -> next cycle ins_out=0x00500513, pc_next_out=0x102, comp_out=1, valid_out=1.
- Sequential stream, not stalled:
  - 0x0000852E -> 0x00B00533
  - 0x00008082 -> 0x00008067
  - 0x00000001 -> 0x00000013
  - 32-bit 0x00150513 at pc 0x104 -> passthrough, pc_next_out=0x108
- ins_in=0x00000000 with comp_in=1 -> illegal_out=1, ins_out=0x00000013, valid_out=1.
- Stall for 3 cycles while fetch presents A then B:
  - outputs hold; A captured in skid, in_ready=0.
  - After stall drops: A, then B, on consecutive cycles; none dropped or duplicated.
- flush asserted with skid full and a valid input -> next cycle valid_out=0, ins_out=0x00000013, in_ready=1; the following accepted input appears normally.
- rst pulse mid-stall (asynchronous, between clock edges) -> outputs immediately at reset values; no stale instruction after release.
